redirection_ctrl_unit: RTL and testbench
========================================

Name: redirection_ctrl_unit

Overview:
- Control-side counterpart of the operand forwarding muxes in the 5-stage MIPS pipeline.
- Watches each instruction leaving ID and keeps a shadow copy of destination/write info for EX, MEM and WB.
- Produces the registered 4-bit redirection_ctrl that the forwarding muxes consume during EX.
- Detects load-use hazards and raises a one-cycle stall that inserts a bubble into EX.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, stall statistics counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- hold  input  1  global pipeline freeze (halt/syscall); all state holds.
- flush  input  1  branch/jump taken; the ID instruction is killed.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_W  source register A.
- id_rt  input  REG_W  source register B.
- id_use_rs  input  1  instruction reads rs.
- id_use_rt  input  1  instruction reads rt.
- id_wreg  input  REG_W  destination register (rd or rt, already selected).
- id_regwrite  input  1  instruction writes the register file.
- id_memread  input  1  instruction is a load.
- stall  output  1  combinational; freezes PC and IF/ID, bubbles EX.
- redirection_ctrl  output  4  registered. Bit 0: A<-alu_out. Bit 1: A<-mem_out. Bit 2: B<-alu_out. Bit 3: B<-mem_out.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Shadow stages ex_, mem_, wb_ each hold {valid, wreg, regwrite, memread}.
- Reset (rst=1 at posedge): all shadow valid=0, redirection_ctrl=4'b0000, stall_count=0. Reset beats hold. Reset mid-stall clears the stall on the next cycle.
- Producer-match definition: a shadow stage matches source s when valid && regwrite && wreg==s && s!=0 && use_s. Register $0 is never forwarded.
- Load-use hazard: ex_ matches id_rs or id_rt, and ex_.memread=1.
- stall = id_valid && !flush && hazard. It is purely combinational and is driven even while hold=1.
- Next redirection_ctrl, computed when the ID instruction enters EX. At that point ex_ becomes the alu_out producer and mem_ becomes the mem_out producer.
  - A: ex_ matches rs (not a load) -> bit0=1, bit1=0. Otherwise mem_ matches rs -> bit1=1. Otherwise both 0.
  - B: same rule using rt, bits 2/3.
  - At most one bit is set per operand; ex_ (youngest) has priority.
- Update at each posedge with rst=0 and hold=0:
  - mem_ <= ex_; wb_ <= mem_.
  - ex_ <= bubble (valid=0) if flush, stall or !id_valid; else the id_* fields.
  - redirection_ctrl <= 0 for a bubble; else the computed value.
  - stall_count <= stall_count+1 if stall and not all-ones; saturates at all-ones, never wraps.
- hold=1: every register keeps its value, including redirection_ctrl and stall_count.
- Latency: redirection_ctrl is valid in the cycle after the instruction's ID cycle, i.e. its EX cycle.
- Load-use timing: one stall cycle. On the retry the load is in MEM. The consumer then forwards through mem_out (bit1/bit3), never alu_out.
- Simultaneous flush and hazard: flush wins. stall=0, bubble inserted, counter unchanged.
- WB-to-ID dependency: not handled here. The register file writes before it reads.

Decomposition:
- Shared package: REG_W, redirection_ctrl bit-index constants (RC_A_ALU=0, RC_A_MEM=1, RC_B_ALU=2, RC_B_MEM=3), and the stage-record field layout.
- One natural sub-module, fwd_select. It is combinational, instantiated once per operand, and takes source, use flag, ex_ record and mem_ record. It returns {mem_sel, alu_sel, load_hazard}.

Test Plan:
- Back-to-back ALU dependency: add $3,$1,$2 then sub $4,$3,$5 -> sub's EX cycle redirection_ctrl=4'b0001, stall never 1.
- Distance-2 dependency: add $3; nop; or $6,$7,$3 -> 4'b1000 in or's EX cycle.
- Both distances, same register: add $3 then add $3 then and $8,$3,$3 -> 4'b0101 (youngest wins).
- Load-use: lw $2,0($1) then add $5,$2,$2 -> stall=1 for exactly one cycle, stall_count=1, EX bubble with ctrl 0000, then add's EX ctrl=4'b1010.
- $0 and no-write cases: add $0,... then use $0 -> 0000. Producer with id_regwrite=0 -> 0000.
- Control interactions:
  - flush asserted during a load-use hazard -> stall=0, counter unchanged.
  - hold=1 for 3 cycles mid-sequence -> outputs frozen, then resume identically.
  - rst in the stall cycle -> next cycle stall=0, ctrl=0, stall_count=0.
  - 65536 forced stalls -> stall_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/redirection_ctrl_unit_pkg.sv
// Shared types and constants for the EX-stage operand redirection controller.
// Bit positions of redirection_ctrl and the shadow pipeline stage record.
package redirection_ctrl_unit_pkg;

  localparam int REG_W     = 5;
  localparam int CNT_W_DEF = 16;

  localparam int RC_A_ALU = 0;
  localparam int RC_A_MEM = 1;
  localparam int RC_B_ALU = 2;
  localparam int RC_B_MEM = 3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wreg;
    logic             regwrite;
    logic             memread;
  } stage_t;

  localparam stage_t STAGE_NONE = '0;

endpackage

// File: rtl/redirection_ctrl_unit_if.sv
// ID-side instruction info in, stall / forwarding control out.
// wb_shadow exposes the oldest shadow stage for observation only.
interface redirection_ctrl_unit_if
  import redirection_ctrl_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_wreg;
  logic             id_regwrite;
  logic             id_memread;
  logic             stall;
  logic [3:0]       redirection_ctrl;
  logic [CNT_W-1:0] stall_count;
  stage_t           wb_shadow;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_regwrite, id_memread,
    input  stall, redirection_ctrl, stall_count, wb_shadow
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wreg, id_regwrite, id_memread,
    output stall, redirection_ctrl, stall_count, wb_shadow
  );

endinterface

// File: rtl/redirection_ctrl_unit_fwd_select.sv
// Per-operand producer match: picks alu_out (EX) over mem_out (MEM) forwarding,
// and flags a load-use hazard when the youngest producer is still a load in EX.
module redirection_ctrl_unit_fwd_select
  import redirection_ctrl_unit_pkg::*;
(
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  input  stage_t           i_ex,
  input  stage_t           i_mem,
  output logic             o_mem_sel,
  output logic             o_alu_sel,
  output logic             o_load_hazard
);

  logic w_src_ok;
  logic w_ex_match;
  logic w_mem_match;

  // $0 is hardwired to zero and must never be redirected
  assign w_src_ok    = i_use && (i_src != '0);
  assign w_ex_match  = w_src_ok && i_ex.valid && i_ex.regwrite && (i_ex.wreg == i_src);
  assign w_mem_match = w_src_ok && i_mem.valid && i_mem.regwrite && (i_mem.wreg == i_src);

  assign o_load_hazard = w_ex_match && i_ex.memread;
  assign o_alu_sel     = w_ex_match && !i_ex.memread;
  assign o_mem_sel     = !w_ex_match && w_mem_match;

endmodule

// File: rtl/redirection_ctrl_unit.sv
// Shadows EX/MEM/WB write info and registers the forwarding mux selects for EX.
// Raises a combinational one-cycle load-use stall that bubbles EX.
module redirection_ctrl_unit
  import redirection_ctrl_unit_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic                    clk,
  input logic                    rst,
  redirection_ctrl_unit_if.slave bus
);

  stage_t           r_ex;
  stage_t           r_mem;
  stage_t           r_wb;
  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_a_mem, w_a_alu, w_a_haz;
  logic       w_b_mem, w_b_alu, w_b_haz;
  logic       w_stall;
  logic       w_bubble;
  logic [3:0] w_ctrl_nxt;
  stage_t     w_id_rec;

  redirection_ctrl_unit_fwd_select u_fwd_a (
    .i_src         (bus.id_rs),
    .i_use         (bus.id_use_rs),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .o_mem_sel     (w_a_mem),
    .o_alu_sel     (w_a_alu),
    .o_load_hazard (w_a_haz)
  );

  redirection_ctrl_unit_fwd_select u_fwd_b (
    .i_src         (bus.id_rt),
    .i_use         (bus.id_use_rt),
    .i_ex          (r_ex),
    .i_mem         (r_mem),
    .o_mem_sel     (w_b_mem),
    .o_alu_sel     (w_b_alu),
    .o_load_hazard (w_b_haz)
  );

  // A taken branch kills the ID instruction, so it can never stall
  assign w_stall  = bus.id_valid && !bus.flush && (w_a_haz || w_b_haz);
  assign w_bubble = bus.flush || w_stall || !bus.id_valid;

  always_comb begin
    w_id_rec          = STAGE_NONE;
    w_id_rec.valid    = 1'b1;
    w_id_rec.wreg     = bus.id_wreg;
    w_id_rec.regwrite = bus.id_regwrite;
    w_id_rec.memread  = bus.id_memread;

    w_ctrl_nxt           = '0;
    w_ctrl_nxt[RC_A_ALU] = w_a_alu;
    w_ctrl_nxt[RC_A_MEM] = w_a_mem;
    w_ctrl_nxt[RC_B_ALU] = w_b_alu;
    w_ctrl_nxt[RC_B_MEM] = w_b_mem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= STAGE_NONE;
      r_mem       <= STAGE_NONE;
      r_wb        <= STAGE_NONE;
      r_ctrl      <= '0;
      r_stall_cnt <= '0;
    end else if (!bus.hold) begin
      r_mem  <= r_ex;
      r_wb   <= r_mem;
      r_ex   <= w_bubble ? STAGE_NONE : w_id_rec;
      r_ctrl <= w_bubble ? 4'b0000 : w_ctrl_nxt;
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.stall            = w_stall;
  assign bus.redirection_ctrl = r_ctrl;
  assign bus.stall_count      = r_stall_cnt;
  assign bus.wb_shadow        = r_wb;

endmodule

// File: tb/tb_redirection_ctrl_unit.sv
// Directed instruction sequences with hand-computed forwarding/stall expectations.
// A narrow-counter twin runs in lockstep to reach counter saturation quickly.
module tb_redirection_ctrl_unit;
  import redirection_ctrl_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, hold, flush, id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_wreg;
  logic             id_use_rs, id_use_rt, id_regwrite, id_memread;

  redirection_ctrl_unit_if #(.CNT_W(16)) bus ();
  redirection_ctrl_unit_if #(.CNT_W(4))  bus_s ();

  assign {bus.hold, bus.flush, bus.id_valid} = {hold, flush, id_valid};
  assign {bus.id_rs, bus.id_rt, bus.id_wreg} = {id_rs, id_rt, id_wreg};
  assign {bus.id_use_rs, bus.id_use_rt, bus.id_regwrite, bus.id_memread} =
         {id_use_rs, id_use_rt, id_regwrite, id_memread};
  assign {bus_s.hold, bus_s.flush, bus_s.id_valid} = {hold, flush, id_valid};
  assign {bus_s.id_rs, bus_s.id_rt, bus_s.id_wreg} = {id_rs, id_rt, id_wreg};
  assign {bus_s.id_use_rs, bus_s.id_use_rt, bus_s.id_regwrite, bus_s.id_memread} =
         {id_use_rs, id_use_rt, id_regwrite, id_memread};

  redirection_ctrl_unit #(.CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  redirection_ctrl_unit #(.CNT_W(4)) u_dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wr,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  // lw $2,0($1) followed by add $5,$2,$2
  task automatic set_lw2();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1);
  endtask
  task automatic set_use2();
    set_id(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b1; flush = 1'b0;
    nop();
    tick(); tick();
    chk("rst_ctrl", bus.redirection_ctrl, 4'b0000);
    chk("rst_cnt", bus.stall_count, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_wb_valid", bus.wb_shadow.valid, 0);
    rst = 1'b0; hold = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    set_id(1, 1, 2, 1, 1, 3, 1, 0); #1 chk("b2b_stall0", bus.stall, 0); tick();
    set_id(1, 3, 5, 1, 1, 4, 1, 0); #1 chk("b2b_stall1", bus.stall, 0); tick();
    chk("b2b_ctrl", bus.redirection_ctrl, 4'b0001);
    nop(); tick();
    chk("nop_ctrl", bus.redirection_ctrl, 4'b0000);
    chk("wb_add3", {bus.wb_shadow.valid, bus.wb_shadow.wreg}, 6'h23);
    drain();

    // add $3 ; nop ; or $6,$7,$3
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    nop(); tick();
    set_id(1, 7, 3, 1, 1, 6, 1, 0); tick();
    chk("dist2_ctrl", bus.redirection_ctrl, 4'b1000);
    drain();

    // add $3 ; add $3,$1,$1 ; and $8,$3,$3
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    set_id(1, 1, 1, 1, 1, 3, 1, 0); tick();
    chk("youngest_mid", bus.redirection_ctrl, 4'b0000);
    set_id(1, 3, 3, 1, 1, 8, 1, 0); tick();
    chk("youngest_ctrl", bus.redirection_ctrl, 4'b0101);
    drain();

    // load-use: one stall, bubble, then mem_out on both operands
    set_lw2(); tick();
    set_use2(); #1 chk("lu_stall", bus.stall, 1); tick();
    chk("lu_bubble", bus.redirection_ctrl, 4'b0000);
    chk("lu_cnt", bus.stall_count, 1);
    #1 chk("lu_retry_stall", bus.stall, 0); tick();
    chk("lu_retry_ctrl", bus.redirection_ctrl, 4'b1010);
    chk("lu_cnt_after", bus.stall_count, 1);
    drain();

    // $0, no-write and unused-source producers never forward
    set_id(1, 1, 2, 1, 1, 0, 1, 0); tick();
    set_id(1, 0, 0, 1, 1, 5, 1, 0); tick();
    chk("zero_reg", bus.redirection_ctrl, 4'b0000);
    set_id(1, 1, 2, 1, 1, 3, 0, 0); tick();
    set_id(1, 3, 3, 1, 1, 9, 1, 0); tick();
    chk("no_write", bus.redirection_ctrl, 4'b0000);
    set_id(1, 3, 3, 0, 0, 10, 1, 0); tick();
    chk("no_use", bus.redirection_ctrl, 4'b0000);
    drain();

    // flush beats load-use
    set_lw2(); tick();
    set_use2(); flush = 1'b1; #1 chk("flush_stall", bus.stall, 0); tick();
    flush = 1'b0;
    chk("flush_ctrl", bus.redirection_ctrl, 4'b0000);
    chk("flush_cnt", bus.stall_count, 1);
    drain();

    // hold freezes everything for 3 cycles, then resumes
    set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
    set_id(1, 3, 5, 1, 1, 4, 1, 0); tick();
    chk("hold_pre", bus.redirection_ctrl, 4'b0001);
    hold = 1'b1;
    set_id(1, 4, 3, 1, 1, 9, 1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ctrl", bus.redirection_ctrl, 4'b0001);
      chk("hold_cnt", bus.stall_count, 1);
    end
    hold = 1'b0; tick();
    chk("hold_resume", bus.redirection_ctrl, 4'b1001);
    drain();

    // stall asserted while hold is high
    set_lw2(); tick();
    hold = 1'b1; set_use2(); #1 chk("hold_stall", bus.stall, 1); tick();
    chk("hold_stall_cnt", bus.stall_count, 1);
    hold = 1'b0; drain();

    // reset in the stall cycle
    set_lw2(); tick();
    set_use2(); #1 chk("rst_mid_stall", bus.stall, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_ctrl", bus.redirection_ctrl, 4'b0000);
    chk("rst_mid_cnt", bus.stall_count, 0);
    chk("rst_mid_cnt_s", bus_s.stall_count, 0);
    #1 chk("rst_mid_stall_after", bus.stall, 0);
    drain();

    // 20 load-use stalls: narrow twin saturates at 15, main counts on
    for (int i = 1; i <= 20; i++) begin
      set_lw2(); tick();
      set_use2(); tick();
      if (i == 15) begin
        chk("sat_s_15", bus_s.stall_count, 15);
        chk("sat_main_15", bus.stall_count, 15);
      end
    end
    chk("sat_s_hold", bus_s.stall_count, 15);
    chk("sat_main_20", bus.stall_count, 20);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
